// File: rtl/mem_pkg.sv
// Shared types and constants for the LC-3 memory-bus responder.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_e;

  typedef enum logic {OP_RD, OP_WR} op_e;

  localparam logic [15:0] IO_ADDR = 16'hFFFF;

endpackage

// File: rtl/mem_array.sv
// Single-port word RAM: synchronous write, synchronous read-first output.
module mem_array #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              Clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       din,
  output logic [15:0]       dout
);

  logic [15:0] mem [2**ADDR_W];

  always_ff @(posedge Clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/mem2io_responder.sv
// LC-3 MAR/MDR bus responder: on-chip RAM plus switch/hex I/O at 0xFFFF, with wait states.
module mem2io_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        Clk,
  input  logic        Reset_ah,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR,
  input  logic        Mem_CE,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [15:0] Switches,
  output logic [15:0] MDR_In,
  output logic        R,
  output logic [15:0] HEX_Out,
  output logic        Err
);

  localparam logic [3:0] WaitCnt = WAIT_STATES[3:0];

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [15:0] mdr_in_q, mdr_in_d;
  logic [15:0] hex_q, hex_d;
  logic        r_q, r_d;
  logic        err_q, err_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_dout;

  logic req, conflict, is_io;

  assign req      = !Mem_CE && (Mem_OE ^ Mem_WE);
  assign conflict = !Mem_CE && !Mem_OE && !Mem_WE;
  assign is_io    = (addr_q == IO_ADDR);

  // With zero wait states the RAM read is issued straight from MAR in IDLE.
  assign ram_addr = (state_q == IDLE) ? MAR[ADDR_W-1:0] : addr_q[ADDR_W-1:0];

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    mdr_in_d = mdr_in_q;
    hex_d    = hex_q;
    err_d    = err_q;
    r_d      = 1'b0;
    ram_we   = 1'b0;

    case (state_q)
      IDLE: begin
        if (conflict) begin
          err_d = 1'b1;
        end else if (req) begin
          addr_d  = MAR;
          data_d  = MDR;
          op_d    = Mem_OE ? OP_WR : OP_RD;
          cnt_d   = WaitCnt;
          state_d = (WaitCnt == 4'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        r_d     = 1'b1;
        state_d = HOLD;
        if (op_q == OP_RD) begin
          mdr_in_d = is_io ? Switches : ram_dout;
        end else if (is_io) begin
          hex_d = data_q;
        end else begin
          ram_we = 1'b1;
        end
      end
      HOLD: begin
        // Wait for the CPU to drop its strobes so a held strobe is one access.
        if (Mem_CE || (Mem_OE && Mem_WE)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset_ah) begin
    if (Reset_ah) begin
      state_q  <= IDLE;
      op_q     <= OP_RD;
      cnt_q    <= 4'd0;
      addr_q   <= 16'd0;
      data_q   <= 16'd0;
      mdr_in_q <= 16'd0;
      hex_q    <= 16'd0;
      r_q      <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      mdr_in_q <= mdr_in_d;
      hex_q    <= hex_d;
      r_q      <= r_d;
      err_q    <= err_d;
    end
  end

  mem_array #(
    .ADDR_W(ADDR_W)
  ) u_mem_array (
    .Clk  (Clk),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (data_q),
    .dout (ram_dout)
  );

  assign MDR_In  = mdr_in_q;
  assign R       = r_q;
  assign HEX_Out = hex_q;
  assign Err     = err_q;

endmodule

// File: tb/tb_mem2io_responder.sv
// Directed bench: two responders (2 and 0 wait states) driven by one shared CPU bus.
module tb_mem2io_responder;

  logic        Clk = 1'b0;
  logic        Reset_ah = 1'b0;
  logic [15:0] MAR = '0;
  logic [15:0] MDR = '0;
  logic        Mem_CE = 1'b1;
  logic        Mem_OE = 1'b1;
  logic        Mem_WE = 1'b1;
  logic [15:0] Switches = '0;

  logic [15:0] mdr_in2, hex2, mdr_in0, hex0;
  logic        r2, err2, r0, err0;

  int n_vec = 0;
  int n_err = 0;
  int fe2, fe0, np2, np0;

  always #5 Clk = ~Clk;

  mem2io_responder #(.ADDR_W(10), .WAIT_STATES(2)) dut (
    .Clk      (Clk),
    .Reset_ah (Reset_ah),
    .MAR      (MAR),
    .MDR      (MDR),
    .Mem_CE   (Mem_CE),
    .Mem_OE   (Mem_OE),
    .Mem_WE   (Mem_WE),
    .Switches (Switches),
    .MDR_In   (mdr_in2),
    .R        (r2),
    .HEX_Out  (hex2),
    .Err      (err2)
  );

  mem2io_responder #(.ADDR_W(10), .WAIT_STATES(0)) dut0 (
    .Clk      (Clk),
    .Reset_ah (Reset_ah),
    .MAR      (MAR),
    .MDR      (MDR),
    .Mem_CE   (Mem_CE),
    .Mem_OE   (Mem_OE),
    .Mem_WE   (Mem_WE),
    .Switches (Switches),
    .MDR_In   (mdr_in0),
    .R        (r0),
    .HEX_Out  (hex0),
    .Err      (err0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset_ah = 1'b1;
    Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1;
    @(negedge Clk);
    Reset_ah = 1'b0;
  endtask

  // Strobes held low for hold_cycles edges (edge 0 = request capture); MAR/MDR are
  // scrambled after edge 0 so only latched values may be used.
  task automatic access(input logic wr, input logic [15:0] a, input logic [15:0] d,
                        input int hold_cycles);
    @(negedge Clk);
    MAR = a; MDR = d; Mem_CE = 1'b0; Mem_OE = wr; Mem_WE = !wr;
    fe2 = -1; fe0 = -1; np2 = 0; np0 = 0;
    for (int e = 0; e < hold_cycles; e++) begin
      @(posedge Clk); #1;
      if (r2) begin np2++; if (fe2 < 0) fe2 = e; end
      if (r0) begin np0++; if (fe0 < 0) fe0 = e; end
      if (e == 0) begin
        MAR = ~a; MDR = ~d;
      end
    end
    @(negedge Clk);
    Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1;
    repeat (2) begin
      @(posedge Clk); #1;
      if (r2) np2++;
      if (r0) np0++;
    end
  endtask

  initial begin
    // 1: reset, then write
    do_reset();
    #1;
    check("rst_r", r2, 0);
    check("rst_mdr_in", mdr_in2, 0);
    check("rst_hex", hex2, 0);
    check("rst_err", err2, 0);
    access(1'b1, 16'h0005, 16'h1234, 8);
    check("wr_r_edge", fe2, 3);
    check("wr_r_pulses", np2, 1);
    check("wr_r_edge_ws0", fe0, 1);
    check("wr_hex_untouched", hex2, 0);
    check("wr_mdr_in_untouched", mdr_in2, 0);

    // 2: read-back, value held after release
    access(1'b0, 16'h0005, 16'h0000, 8);
    check("rd_r_edge", fe2, 3);
    check("rd_data", mdr_in2, 16'h1234);
    check("rd_data_ws0", mdr_in0, 16'h1234);
    repeat (3) @(posedge Clk);
    #1 check("rd_data_held", mdr_in2, 16'h1234);

    // 3: memory-mapped I/O and output isolation
    Switches = 16'hBEEF;
    access(1'b1, 16'h03FF, 16'h0ABC, 6);
    access(1'b0, 16'hFFFF, 16'h0000, 6);
    check("io_rd_switches", mdr_in2, 16'hBEEF);
    check("io_rd_hex_untouched", hex2, 0);
    Switches = 16'h1111;
    access(1'b1, 16'hFFFF, 16'h00A5, 6);
    check("io_wr_hex", hex2, 16'h00A5);
    check("io_wr_hex_ws0", hex0, 16'h00A5);
    check("io_wr_mdr_in_untouched", mdr_in2, 16'hBEEF);
    access(1'b0, 16'h03FF, 16'h0000, 6);
    check("ram_3ff_intact", mdr_in2, 16'h0ABC);

    // 4: strobe held for 10 cycles gives one pulse; re-strobe gives another
    access(1'b0, 16'h0005, 16'h0000, 10);
    check("hold_pulses", np2, 1);
    check("hold_pulses_ws0", np0, 1);
    access(1'b0, 16'h0005, 16'h0000, 10);
    check("restrobe_pulses", np2, 1);
    check("restrobe_edge", fe2, 3);

    // 5: strobe conflict is sticky; RAM aliasing above ADDR_W
    @(negedge Clk);
    MAR = 16'h0005; Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b0;
    np2 = 0;
    repeat (4) begin
      @(posedge Clk); #1;
      if (r2) np2++;
    end
    check("conflict_err", err2, 1);
    check("conflict_no_r", np2, 0);
    @(negedge Clk);
    Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1;
    repeat (5) @(posedge Clk);
    #1 check("conflict_err_sticky", err2, 1);
    check("conflict_mdr_in_untouched", mdr_in2, 16'h1234);
    access(1'b1, 16'h0405, 16'h7777, 6);
    access(1'b0, 16'h0005, 16'h0000, 6);
    check("alias_rd", mdr_in2, 16'h7777);

    // 6: reset during WAIT aborts the write
    access(1'b1, 16'h0009, 16'h4242, 6);
    @(negedge Clk);
    MAR = 16'h0009; MDR = 16'h5555; Mem_CE = 1'b0; Mem_OE = 1'b1; Mem_WE = 1'b0;
    @(posedge Clk); #1;
    Reset_ah = 1'b1;
    #1;
    check("abort_r", r2, 0);
    check("abort_mdr_in", mdr_in2, 0);
    check("abort_hex", hex2, 0);
    check("abort_err", err2, 0);
    np2 = 0; np0 = 0;
    repeat (3) begin
      @(posedge Clk); #1;
      if (r2) np2++;
      if (r0) np0++;
    end
    check("abort_no_r", np2, 0);
    check("abort_no_r_ws0", np0, 0);
    @(negedge Clk);
    Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1; Reset_ah = 1'b0;
    access(1'b0, 16'h0009, 16'h0000, 6);
    check("abort_ram_prior", mdr_in2, 16'h4242);
    check("abort_ram_prior_ws0", mdr_in0, 16'h4242);
    access(1'b1, 16'h0005, 16'h1234, 6);
    check("ws0_r_edge", fe0, 1);
    check("ws0_r_pulses", np0, 1);
    check("ws2_r_edge", fe2, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
